// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the DDR user-port arbiter.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_VGA, GNT_CAM, GNT_HDR} state_t;
  localparam logic [2:0] APP_CMD_RD = 3'b001;
  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [1:0] REQ_VGA = 2'd0;
  localparam logic [1:0] REQ_CAM = 2'd1;
  localparam logic [1:0] REQ_HDR = 2'd2;
endpackage

// File: rtl/ram_tag_fifo.sv
// ram_tag_fifo: 1-bit sync FIFO recording which reader owns each outstanding DDR read.
module ram_tag_fifo #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one DDR user port among VGA reads, camera writes and HDR read/write.
// Define ARB_ROUND_ROBIN_EN to alternate CAM/HDR on ties; otherwise fixed VGA > CAM > HDR.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 80,
  parameter int TAG_DEPTH = 32
) (
  input  logic              clk,
  input  logic              ui_rst_n,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_address,
  output logic              vga_ack,
  output logic              vga_rd_valid,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_wr_address,
  input  logic [DATA_W-1:0] cam_wr_data,
  output logic              cam_ack,
  input  logic              hdr_req,
  input  logic              hdr_we,
  input  logic [ADDR_W-1:0] hdr_address,
  input  logic [DATA_W-1:0] hdr_wr_data,
  output logic              hdr_ack,
  output logic              hdr_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              ram_busy,
  output logic              tag_err
);
  state_t state;
  logic [6:0] burst_cnt;
  logic owner_req, owner_rd, accept, release_gnt, pick_hdr;
  logic tag_full, tag_empty, tag_head;
  always_comb begin
    owner_req = state == GNT_VGA ? vga_rd_req : state == GNT_CAM ? cam_wr_req :
                state == GNT_HDR ? hdr_req : 1'b0;
    owner_rd = state == GNT_VGA || (state == GNT_HDR && !hdr_we);
    app_addr = state == GNT_CAM ? cam_wr_address : state == GNT_HDR ? hdr_address : vga_rd_address;
    app_wdf_data = state == GNT_CAM ? cam_wr_data : hdr_wr_data;
    app_cmd = owner_rd ? APP_CMD_RD : APP_CMD_WR;
    // a write command is withheld unless its data can go in the same cycle
    app_en = owner_req & (owner_rd ? ~tag_full : ~(app_rdy & ~app_wdf_rdy));
    accept = app_en & app_rdy;
    app_wdf_wren = accept & ~owner_rd;
    app_wdf_end = app_wdf_wren;
    vga_ack = accept & (state == GNT_VGA);
    cam_ack = accept & (state == GNT_CAM);
    hdr_ack = accept & (state == GNT_HDR);
    vga_rd_valid = app_rd_data_valid & ~tag_empty & ~tag_head;
    hdr_rd_valid = app_rd_data_valid & ~tag_empty & tag_head;
    release_gnt = ~owner_req | (accept & burst_cnt == 7'(MAX_BURST - 1)) |
                  (vga_rd_req & state != GNT_VGA);
  end
  assign rd_data = app_rd_data;
  assign ram_busy = state != IDLE || !tag_empty;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_hdr;
  assign pick_hdr = hdr_req & (~cam_wr_req | ~last_hdr);
  always_ff @(posedge clk or negedge ui_rst_n) begin
    if (!ui_rst_n) last_hdr <= 1'b1;
    else if (state == IDLE && !vga_rd_req && (cam_wr_req || hdr_req)) last_hdr <= pick_hdr;
  end
`else
  assign pick_hdr = hdr_req & ~cam_wr_req;
`endif
  always_ff @(posedge clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state <= IDLE;
      burst_cnt <= '0;
      tag_err <= 1'b0;
    end else begin
      if (app_rd_data_valid && tag_empty) tag_err <= 1'b1;
      if (state == IDLE) begin
        burst_cnt <= '0;
        state <= vga_rd_req ? GNT_VGA : pick_hdr ? GNT_HDR : cam_wr_req ? GNT_CAM : IDLE;
      end else begin
        if (accept) burst_cnt <= burst_cnt + 7'd1;
        if (release_gnt) state <= IDLE;
      end
    end
  end
  ram_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk),
    .rst_n(ui_rst_n),
    .push(accept & owner_rd),
    .din(state == GNT_HDR),
    .pop(app_rd_data_valid),
    .dout(tag_head),
    .full(tag_full),
    .empty(tag_empty)
  );
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with requester/DDR responder models and per-accept checks.
module tb_ram_arbiter;
  logic clk = 0, ui_rst_n;
  logic vga_rd_req, vga_ack, vga_rd_valid;
  logic [26:0] vga_rd_address, cam_wr_address, hdr_address, app_addr;
  logic cam_wr_req, cam_ack, hdr_req, hdr_we, hdr_ack, hdr_rd_valid;
  logic [127:0] cam_wr_data, hdr_wr_data, rd_data, app_wdf_data, app_rd_data;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
  logic [2:0] app_cmd;
  logic ram_busy, tag_err;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .ui_rst_n(ui_rst_n),
    .vga_rd_req(vga_rd_req), .vga_rd_address(vga_rd_address), .vga_ack(vga_ack), .vga_rd_valid(vga_rd_valid),
    .cam_wr_req(cam_wr_req), .cam_wr_address(cam_wr_address), .cam_wr_data(cam_wr_data), .cam_ack(cam_ack),
    .hdr_req(hdr_req), .hdr_we(hdr_we), .hdr_address(hdr_address), .hdr_wr_data(hdr_wr_data),
    .hdr_ack(hdr_ack), .hdr_rd_valid(hdr_rd_valid), .rd_data(rd_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .ram_busy(ram_busy), .tag_err(tag_err)
  );

  typedef struct {int t; logic id; logic [127:0] d;} rsp_t;
  rsp_t rq[$];
  int glog[$];
  int checks = 0, failures = 0;
  int cyc_n = 0, lat = 1, rseq = 0;
  int vga_left = 0, cam_left = 0, hdr_left = 0, hdr_mode = 0;
  int vga_acks, cam_acks, hdr_acks, vga_valids, hdr_valids, vga_gap;
  int last_owner, cam_at_vga, cam_at_hdr, stall_left = 0;
  logic [26:0] vga_a = 0, cam_a = 0, hdr_a = 0;
  bit hold_rd = 0, inj = 0, have = 0, wdf_lo = 0, trig3 = 0, trig4 = 0;
  logic exp_id;
  logic [127:0] exp_d;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] cam_dat(logic [26:0] a);
    return {4{5'd0, a}};
  endfunction

  function automatic int lg(int i);
    return i < glog.size() ? glog[i] : -1;
  endfunction

  task automatic clr();
    vga_acks = 0; cam_acks = 0; hdr_acks = 0; vga_valids = 0; hdr_valids = 0; vga_gap = 0;
    last_owner = -1; cam_at_vga = -1; cam_at_hdr = -1;
    glog.delete();
  endtask

  task automatic note(int id);
    if (id != last_owner) glog.push_back(id);
    last_owner = id;
  endtask

  task automatic push_rd(logic id);
    rseq++;
    rq.push_back('{cyc_n + lat, id, {id, 95'd0, 32'(rseq)}});
  endtask

  task automatic drive();
    if (trig3 && cam_acks == 20) begin vga_left = 10; trig3 = 0; end
    if (trig4 && hdr_acks == 3) begin vga_left = 4; trig4 = 0; end
    vga_rd_req = vga_left > 0; vga_rd_address = vga_a;
    cam_wr_req = cam_left > 0; cam_wr_address = cam_a; cam_wr_data = cam_dat(cam_a);
    hdr_req = hdr_left > 0; hdr_address = hdr_a; hdr_wr_data = ~cam_dat(hdr_a);
    hdr_we = hdr_mode == 2 ? hdr_left[0] : hdr_mode[0];
    wdf_lo = cam_acks == 10 && stall_left > 0;
    app_rdy = 1; app_wdf_rdy = !wdf_lo;
    have = 0; app_rd_data_valid = inj; app_rd_data = 0;
    if (!inj && !hold_rd && rq.size() > 0 && rq[0].t <= cyc_n) begin
      have = 1; exp_id = rq[0].id; exp_d = rq[0].d; rq.pop_front();
      app_rd_data_valid = 1; app_rd_data = exp_d;
    end
  endtask

  task automatic sample();
    if (have) begin
      check("vga_rd_valid", vga_rd_valid, !exp_id);
      check("hdr_rd_valid", hdr_rd_valid, exp_id);
      check("rd_data", rd_data, exp_d);
    end
    if (inj) begin
      check("inj_vga_valid", vga_rd_valid, 0);
      check("inj_hdr_valid", hdr_rd_valid, 0);
    end
    if (vga_rd_valid) vga_valids++;
    if (hdr_rd_valid) hdr_valids++;
    if (vga_rd_req && !vga_ack) vga_gap++;
    if (wdf_lo) begin
      check("stall_app_en", app_en, 0);
      check("stall_cam_ack", cam_ack, 0);
      stall_left--;
    end
    if (vga_ack) begin
      check("vga_addr", app_addr, vga_a);
      check("vga_cmd", app_cmd, 3'b001);
      push_rd(0);
      if (cam_at_vga < 0) cam_at_vga = cam_acks;
      vga_a = vga_a + 27'd8; vga_left--; vga_acks++; note(0);
    end
    if (cam_ack) begin
      check("cam_addr", app_addr, cam_a);
      check("cam_cmd", app_cmd, 3'b000);
      check("cam_wren", {app_wdf_wren, app_wdf_end}, 2'b11);
      check("cam_data", app_wdf_data, cam_dat(cam_a));
      cam_a = cam_a + 27'd8; cam_left--; cam_acks++; note(1);
    end
    if (hdr_ack) begin
      check("hdr_addr", app_addr, hdr_a);
      if (hdr_we) begin
        check("hdr_wcmd", app_cmd, 3'b000);
        check("hdr_wren", app_wdf_wren, 1);
        check("hdr_data", app_wdf_data, ~cam_dat(hdr_a));
      end else begin
        check("hdr_rcmd", app_cmd, 3'b001);
        push_rd(1);
      end
      if (cam_at_hdr < 0) cam_at_hdr = cam_acks;
      hdr_a = hdr_a + 27'd8; hdr_left--; hdr_acks++; note(2);
    end
    cyc_n++;
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(negedge clk);
      drive();
      #2;
      sample();
    end
  endtask

  initial begin
    clr();
    ui_rst_n = 0;
    run(3);
    check("rst_app_en", app_en, 0);
    check("rst_acks", {vga_ack, cam_ack, hdr_ack}, 0);
    check("rst_valids", {vga_rd_valid, hdr_rd_valid}, 0);
    check("rst_wren", {app_wdf_wren, app_wdf_end}, 0);
    check("rst_busy", ram_busy, 0);
    check("rst_tag_err", tag_err, 0);
    @(negedge clk); ui_rst_n = 1;

    clr(); lat = 1; vga_a = 27'h1000; vga_left = 80;
    run(90);
    check("t1_acks", vga_acks, 80);
    check("t1_addr", vga_a, 27'h1000 + 27'd640);
    check("t1_gap", vga_gap, 1);
    check("t1_valids", vga_valids, 80);
    check("t1_busy", ram_busy, 0);

    clr(); vga_left = 81;
    run(95);
    check("t1b_acks", vga_acks, 81);
    check("t1b_gap", vga_gap, 2);

    clr(); cam_a = 27'h2000; cam_left = 30; stall_left = 3;
    run(40);
    check("t2_acks", cam_acks, 30);
    check("t2_addr", cam_a, 27'h2000 + 27'd240);
    check("t2_stalls", stall_left, 0);

    clr(); cam_left = 40; trig3 = 1;
    run(70);
    check("t3_cam_at_vga", cam_at_vga, 21);
    check("t3_g0", lg(0), 1);
    check("t3_g1", lg(1), 0);
    check("t3_g2", lg(2), 1);
    check("t3_cam_acks", cam_acks, 40);
    check("t3_vga_acks", vga_acks, 10);

    clr(); lat = 10; hdr_mode = 0; hdr_a = 27'h3000; hdr_left = 6; trig4 = 1;
    run(50);
    check("t4_g0", lg(0), 2);
    check("t4_g1", lg(1), 0);
    check("t4_g2", lg(2), 2);
    check("t4_vga_valids", vga_valids, 4);
    check("t4_hdr_valids", hdr_valids, 6);
    check("t4_busy", ram_busy, 0);

    clr(); lat = 2; hdr_mode = 2; hdr_left = 8;
    run(20);
    check("t4b_acks", hdr_acks, 8);
    check("t4b_valids", hdr_valids, 4);

    clr(); lat = 1; hold_rd = 1; vga_left = 33;
    run(40);
    check("t5_acks_full", vga_acks, 32);
    check("t5_en_blocked", app_en, 0);
    check("t5_busy", ram_busy, 1);
    hold_rd = 0;
    run(40);
    check("t5_acks", vga_acks, 33);
    check("t5_valids", vga_valids, 33);
    check("t5_busy_end", ram_busy, 0);

    clr(); hdr_mode = 1; cam_left = 200; hdr_left = 200;
    run(420);
    check("t6_cam_acks", cam_acks, 200);
    check("t6_hdr_acks", hdr_acks, 200);
    check("t6_g0", lg(0), 1);
    check("t6_g1", lg(1), 2);
`ifdef ARB_ROUND_ROBIN_EN
    check("t6_g2", lg(2), 1);
    check("t6_cam_at_hdr", cam_at_hdr, 80);
`else
    check("t6_cam_at_hdr", cam_at_hdr, 200);
`endif

    clr(); inj = 1;
    run(1);
    inj = 0;
    run(1);
    check("t7_tag_err", tag_err, 1);

    clr(); hold_rd = 1; hdr_mode = 0; vga_left = 20;
    run(10);
    check("t8_busy_pre", ram_busy, 1);
    @(negedge clk); ui_rst_n = 0;
    #2;
    check("t8_busy", ram_busy, 0);
    check("t8_tag_err", tag_err, 0);
    check("t8_app_en", app_en, 0);
    rq.delete(); vga_left = 0; hold_rd = 0;
    run(2);
    @(negedge clk); ui_rst_n = 1;
    run(3);
    check("t8_after", {vga_rd_valid, ram_busy, app_en}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
